phase_sequencer: RTL
====================

// Module: phase_sequencer
// PURPOSE
//   Parametrised instruction-phase sequencer for the SIMPLE CPU control path; successor to the fixed 4-phase counter.
//   Steps a one-hot phase vector through NUM_PHASES phases per instruction.
//   Adds per-phase wait states, stall hold, early instruction end, halt/resume and a retired-instruction counter.
//   Sits between the top-level clock/reset and the datapath control decoder, which gates register/memory enables by phase.
// PARAMETERS
//   NUM_PHASES  5   phases per full instruction (>=2)
//   WAIT_W      2   width of each per-phase wait-state count (0..2^WAIT_W-1 extra cycles)
//   CNT_W       16  width of retired-instruction counter
//   IDX_W       $clog2(NUM_PHASES)  derived localparam, not overridable
// PORTS
//   clock        in   1                   system clock, rising edge
//   reset        in   1                   synchronous, active-high
//   stall        in   1                   hold current phase and wait count this cycle
//   early_end    in   1                   current phase is the instruction's last (short instruction)
//   halt_req     in   1                   level: halt at next instruction boundary
//   resume       in   1                   leave HALT, restart at phase 0
//   wait_cfg     in   NUM_PHASES*WAIT_W   extra cycles for phase i in bits [i*WAIT_W +: WAIT_W]
//   phase        out  NUM_PHASES          one-hot active phase; all-zero while halted
//   phase_idx    out  IDX_W               binary index of active phase
//   phase_first  out  1                   high in first cycle of a phase occupancy
//   instr_done   out  1                   comb: high in final cycle of an instruction (advance out of last/early_end phase)
//   halted       out  1                   high while in HALT
//   instr_count  out  CNT_W               instructions retired, wraps modulo 2^CNT_W
// BEHAVIOUR
//   - Reset: state RUN, phase_idx=0, phase=1 (bit0), wait_cnt=0, phase_first=1, halted=0, instr_count=0. Reset overrides all inputs.
//   - All outputs except instr_done are registered; phase always equals 1<<phase_idx in RUN.
//   - RUN, per cycle, cfg = wait_cfg[phase_idx]:
//       stall=1 -> hold idx, wait_cnt, phase; phase_first cleared; instr_done=0.
//       stall=0, wait_cnt < cfg -> wait_cnt+1, hold phase.
//       stall=0, wait_cnt >= cfg -> advance (>= so lowering cfg mid-phase never deadlocks); wait_cnt<=0; phase_first<=1 next cycle.
//   - Advance target: idx==NUM_PHASES-1 or early_end=1 -> boundary: instr_done=1, instr_count+1, idx<=0; else idx<=idx+1.
//   - early_end is sampled only on the advance cycle; ignored during wait or stall cycles. Asserting it in phase NUM_PHASES-1 is harmless.
//   - Phase latency: phase i occupies exactly 1+cfg[i] unstalled cycles; an unstalled, zero-wait instruction takes NUM_PHASES cycles.
//   - Halt: at a boundary with halt_req=1, next state HALT: phase=0, idx=0, halted=1, instr_count still increments for the finishing instruction.
//     halt_req outside a boundary has no effect; it must still be high at the boundary to halt.
//   - HALT: stall/early_end/wait_cfg ignored. resume=1 -> next cycle RUN, idx=0, phase=1, phase_first=1, halted=0.
//     halt_req and resume both high in HALT -> resume wins for one instruction; halt is taken again at its boundary.
//   - stall has priority over advance, early_end and halt. A boundary is never recognised on a stalled cycle.
//   - instr_count wraps 2^CNT_W-1 -> 0 silently.
// STRUCTURE
//   - simple_cpu_pkg: seq_state_t enum {SEQ_RUN, SEQ_HALT}; localparam DEFAULT_NUM_PHASES=5; phase_onehot() function.
//   - Sub-module phase_wait_timer: wait_cnt register, compare against selected cfg, outputs done; inputs clear/enable.
//   - Top: state FSM, index register + one-hot decode register, retire counter.
// TESTING
//   1. Reset, wait_cfg=0, no stall: phase 00001,00010,00100,01000,10000,00001; instr_done high only in the 10000 cycle; instr_count=1.
//   2. wait_cfg phase2=3, others 0: phase 00100 held 4 cycles; phase_first high only in its first; instruction = 8 cycles.
//   3. stall for 3 cycles during phase1 wait (cfg=2): phase held; wait_cnt frozen; phase1 total = 3 stall + 3 = 6 cycles.
//   4. early_end=1 in phase2 advance cycle: next phase 00001; instr_done high that cycle; count +1; with stall=1 same cycle: no effect.
//   5. halt_req pulsed in phase1 only: no halt. halt_req held through boundary: phase=0, halted=1; resume -> phase 00001 next cycle.
//   6. reset asserted mid-phase3 with wait pending: next cycle phase=00001, wait_cnt=0, instr_count=0. CNT_W=4: 16 instructions -> count wraps to 0.

Source files
------------

// File: rtl/phase_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// phase_sequencer_pkg
//   Shared types and helpers for the instruction-phase sequencer.
//   - seq_state_t     : top-level sequencer state (running / halted)
//   - DEFAULT_NUM_PHASES : phases per full instruction in the stock CPU
//   - phase_onehot()  : binary phase index -> one-hot phase vector (<=32 phases)
// -----------------------------------------------------------------------------
package phase_sequencer_pkg;

  typedef enum logic {
    SEQ_RUN  = 1'b0,
    SEQ_HALT = 1'b1
  } seq_state_t;

  localparam int DEFAULT_NUM_PHASES = 5;

  // Callers cast the result down to their phase width.
  function automatic logic [31:0] phase_onehot(input logic [31:0] idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// -----------------------------------------------------------------------------
// phase_sequencer_if
//   Control/status bundle between the CPU control path and the phase sequencer.
//   master : drives stall, early_end, halt_req, resume, wait_cfg
//   slave  : the sequencer; drives phase, phase_idx, phase_first, instr_done,
//            halted, instr_count
//   wait_cfg packs one WAIT_W-bit extra-cycle count per phase, phase i in
//   bits [i*WAIT_W +: WAIT_W].
// -----------------------------------------------------------------------------
interface phase_sequencer_if
  import phase_sequencer_pkg::*;
#(
  parameter int NUM_PHASES = DEFAULT_NUM_PHASES,
  parameter int WAIT_W     = 2,
  parameter int CNT_W      = 16
);
  localparam int IDX_W = $clog2(NUM_PHASES);

  logic                         stall;
  logic                         early_end;
  logic                         halt_req;
  logic                         resume;
  logic [NUM_PHASES*WAIT_W-1:0] wait_cfg;

  logic [NUM_PHASES-1:0]        phase;
  logic [IDX_W-1:0]             phase_idx;
  logic                         phase_first;
  logic                         instr_done;
  logic                         halted;
  logic [CNT_W-1:0]             instr_count;

  modport master (
    output stall, early_end, halt_req, resume, wait_cfg,
    input  phase, phase_idx, phase_first, instr_done, halted, instr_count
  );

  modport slave (
    input  stall, early_end, halt_req, resume, wait_cfg,
    output phase, phase_idx, phase_first, instr_done, halted, instr_count
  );

endinterface

// File: rtl/phase_sequencer_wait_timer.sv
// -----------------------------------------------------------------------------
// phase_wait_timer
//   Per-phase wait-state counter. Counts extra cycles spent in the current
//   phase and flags when the selected configuration has been met.
//   clock, reset : system clock, synchronous active-high reset
//   clear_i      : zero the count (phase advance, or not running)
//   enable_i     : count one more wait cycle
//   cfg_i        : extra cycles required for the current phase
//   done_o       : count has reached (or passed) cfg_i -> phase may advance
// -----------------------------------------------------------------------------
module phase_wait_timer #(
  parameter int WAIT_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              enable_i,
  input  logic [WAIT_W-1:0] cfg_i,
  output logic              done_o
);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (clear_i)       wait_cnt_d = '0;
    else if (enable_i) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) wait_cnt_q <= '0;
    else       wait_cnt_q <= wait_cnt_d;
  end

  // >= rather than == : if cfg is lowered below the running count mid-phase,
  // the phase still advances instead of waiting for a wrap.
  assign done_o = (wait_cnt_q >= cfg_i);

endmodule

// File: rtl/phase_sequencer.sv
// -----------------------------------------------------------------------------
// phase_sequencer
//   Instruction-phase sequencer for the SIMPLE CPU control path. Steps a
//   one-hot phase vector through NUM_PHASES phases per instruction, with
//   per-phase wait states, stall hold, early instruction end, halt/resume at
//   instruction boundaries and a retired-instruction counter.
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : control inputs stall/early_end/halt_req/resume/wait_cfg;
//                  status outputs phase/phase_idx/phase_first/halted/
//                  instr_count (registered) and instr_done (combinational,
//                  high in the final cycle of an instruction).
// -----------------------------------------------------------------------------
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int NUM_PHASES = DEFAULT_NUM_PHASES,
  parameter int WAIT_W     = 2,
  parameter int CNT_W      = 16
) (
  input  logic                clock,
  input  logic                reset,
  phase_sequencer_if.slave    bus
);

  localparam int IDX_W = $clog2(NUM_PHASES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHASES - 1);

  seq_state_t            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_PHASES-1:0] phase_q, phase_d;
  logic                  first_q, first_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [WAIT_W-1:0]     cfg_sel;
  logic                  run;
  logic                  wait_done;
  logic                  wait_en;
  logic                  wait_clr;
  logic                  advance;
  logic                  boundary;

  // Wait config for the active phase.
  always_comb begin
    cfg_sel = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (idx_q == IDX_W'(i)) cfg_sel = bus.wait_cfg[i*WAIT_W +: WAIT_W];
    end
  end

  assign run      = (state_q == SEQ_RUN);
  // stall outranks everything: no count, no advance, no boundary.
  assign advance  = run & ~bus.stall & wait_done;
  assign wait_en  = run & ~bus.stall & ~wait_done;
  assign wait_clr = ~run | advance;
  // early_end only matters on the advance cycle.
  assign boundary = advance & ((idx_q == LAST_IDX) | bus.early_end);

  phase_wait_timer #(.WAIT_W(WAIT_W)) u_wait (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (wait_clr),
    .enable_i (wait_en),
    .cfg_i    (cfg_sel),
    .done_o   (wait_done)
  );

  // Next-state / next-output logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    first_d = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      SEQ_RUN: begin
        if (advance) begin
          first_d = 1'b1;
          if (boundary) begin
            idx_d = '0;
            cnt_d = cnt_q + CNT_W'(1);
            // halt_req is only looked at here, so a pulse mid-instruction
            // is dropped.
            if (bus.halt_req) begin
              state_d = SEQ_HALT;
              first_d = 1'b0;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      SEQ_HALT: begin
        idx_d = '0;
        // resume beats a concurrent halt_req; the halt is re-taken at the
        // end of the instruction that resume starts.
        if (bus.resume) begin
          state_d = SEQ_RUN;
          first_d = 1'b1;
        end
      end
      default: begin
        state_d = SEQ_RUN;
        idx_d   = '0;
        first_d = 1'b1;
      end
    endcase
    // The one-hot vector is registered alongside the index so the decoder
    // sees a clean flop output; it is blanked while halted.
    phase_d = (state_d == SEQ_RUN) ? NUM_PHASES'(phase_onehot(32'(idx_d)))
                                   : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SEQ_RUN;
      idx_q   <= '0;
      phase_q <= NUM_PHASES'(1);
      first_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.phase       = phase_q;
  assign bus.phase_idx   = idx_q;
  assign bus.phase_first = first_q;
  assign bus.halted      = (state_q == SEQ_HALT);
  assign bus.instr_count = cnt_q;
  // Reset forces a clean cycle so the decoder never sees a retire under reset.
  assign bus.instr_done  = boundary & ~reset;

endmodule
